// File: rtl/rice_csr_hpm_pkg.sv
// Shared definitions for the rice performance-counter CSR block: address map,
// privilege encoding, request bundle and the CSR address decoder.
package rice_csr_hpm_pkg;

    localparam logic [3:0]  CSR_MCNT_PAGE     = 4'hB;
    localparam logic [3:0]  CSR_UCNT_PAGE     = 4'hC;
    localparam logic [11:0] CSR_MCOUNTEREN    = 12'h306;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

    typedef enum logic [1:0] {
        PRIV_U = 2'd0,
        PRIV_M = 2'd3
    } priv_e;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [11:0] address;
        logic [63:0] data;
        priv_e       privilege;
    } rice_csr_hpm_access_t;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MCNT,
        SEL_UCNT,
        SEL_EVENT,
        SEL_COUNTEREN,
        SEL_INHIBIT
    } csr_sel_e;

    typedef struct packed {
        csr_sel_e   sel;
        logic [4:0] index;
        logic       high;
    } csr_decode_t;

    // Index 1 (the time CSR slot) is not owned by this block and decodes as unmapped.
    function automatic csr_decode_t decode_csr(input logic [11:0] addr);
        csr_decode_t d;
        d.sel   = SEL_NONE;
        d.index = addr[4:0];
        d.high  = addr[7];
        if (addr[6:5] == 2'b00 && addr[4:0] != 5'd1) begin
            if (addr[11:8] == CSR_MCNT_PAGE)      d.sel = SEL_MCNT;
            else if (addr[11:8] == CSR_UCNT_PAGE) d.sel = SEL_UCNT;
        end
        if (addr == CSR_MCOUNTEREN)
            d.sel = SEL_COUNTEREN;
        else if (addr == CSR_MCOUNTINHIBIT)
            d.sel = SEL_INHIBIT;
        else if (addr[11:5] == CSR_MCOUNTINHIBIT[11:5] && addr[4:0] >= 5'd3)
            d.sel = SEL_EVENT;
        return d;
    endfunction

endpackage

// File: rtl/rice_csr_hpm_counter.sv
// One 64-bit wrapping counter with half/whole CSR write and a registered wrap pulse.
module rice_csr_hpm_counter
    import rice_csr_hpm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            inc_i,
    input  logic            wr_lo_i,
    input  logic            wr_hi_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [63:0]     value_o,
    output logic            wrap_o
);

    logic [63:0] cnt_q, cnt_d;
    logic        wrap_q, wrap_d;

    // A write to either half suppresses that cycle's increment and its carry.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (wr_lo_i || wr_hi_i) begin
            if (XLEN == 64) begin
                cnt_d = 64'(wdata_i);
            end else begin
                if (wr_lo_i) cnt_d[31:0]  = wdata_i[31:0];
                if (wr_hi_i) cnt_d[63:32] = wdata_i[31:0];
            end
        end else if (inc_i) begin
            cnt_d  = cnt_q + 64'd1;
            wrap_d = &cnt_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign value_o = cnt_q;
    assign wrap_o  = wrap_q;

endmodule

// File: rtl/rice_csr_hpm_counters.sv
// Machine/user performance-counter CSR block: owns mcycle, minstret and the
// programmable HPM counters, and answers CSR requests one cycle later.
module rice_csr_hpm_counters
    import rice_csr_hpm_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int HPM_COUNTERS = 4,
    parameter int EVENT_WIDTH  = 8,
    localparam int OVF_W       = (HPM_COUNTERS > 0) ? HPM_COUNTERS : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_csr_valid,
    input  logic                   i_csr_write,
    input  logic [11:0]            i_csr_address,
    input  logic [XLEN-1:0]        i_csr_write_data,
    input  logic [1:0]             i_csr_privilege,
    output logic                   o_csr_ready,
    output logic [XLEN-1:0]        o_csr_read_data,
    output logic                   o_csr_error,
    input  logic                   i_retire,
    input  logic [EVENT_WIDTH-1:0] i_events,
    output logic [OVF_W-1:0]       o_overflow
);

    localparam int          NSLOT    = 2 + HPM_COUNTERS;
    localparam int          EVT_W    = $clog2(EVENT_WIDTH + 1);
    localparam logic [31:0] CNT_MASK = 32'((64'd1 << (3 + HPM_COUNTERS)) - 64'd1);
    localparam logic [31:0] INH_MASK = CNT_MASK & ~32'h2;

    rice_csr_hpm_access_t req;
    csr_decode_t          dec;
    logic                 priv_m, err, wr_ok;
    logic [XLEN-1:0]      rdata;
    logic [63:0]          cnt_sel;
    logic [63:0]          cnt_val [NSLOT];
    logic [NSLOT-1:0]     cnt_inc, cnt_wr_lo, cnt_wr_hi, cnt_wrap;
    logic [31:0]          counteren_q, inhibit_q;
    logic [EVT_W-1:0]     event_q [OVF_W];
    logic                 ready_q, error_q;
    logic [XLEN-1:0]      rdata_q;
    logic                 unused_sig;

    assign req = '{valid:     i_csr_valid,
                   write:     i_csr_write,
                   address:   i_csr_address,
                   data:      64'(i_csr_write_data),
                   privilege: priv_e'(i_csr_privilege)};
    assign dec    = decode_csr(req.address);
    assign priv_m = (req.privilege == PRIV_M);
    assign wr_ok  = req.valid && req.write && !err;

    always_comb begin
        err = 1'b0;
        case (dec.sel)
            SEL_MCNT:  err = !priv_m || (dec.high && XLEN == 64);
            SEL_UCNT:  err = req.write || (dec.high && XLEN == 64) ||
                             (!priv_m && !counteren_q[dec.index]);
            SEL_EVENT, SEL_COUNTEREN, SEL_INHIBIT: err = !priv_m;
            default:   err = 1'b1;
        endcase
    end

    // Unimplemented counter/event indices fall through every match and read as 0.
    always_comb begin
        cnt_sel = '0;
        for (int s = 0; s < NSLOT; s++)
            if (int'(dec.index) == ((s == 0) ? 0 : s + 1)) cnt_sel = cnt_val[s];
        rdata = '0;
        case (dec.sel)
            SEL_MCNT, SEL_UCNT: rdata = dec.high ? XLEN'(cnt_sel[63:32]) : cnt_sel[XLEN-1:0];
            SEL_EVENT: begin
                for (int k = 0; k < HPM_COUNTERS; k++)
                    if (int'(dec.index) == 3 + k) rdata = XLEN'(event_q[k]);
            end
            SEL_COUNTEREN: rdata = XLEN'(counteren_q);
            SEL_INHIBIT:   rdata = XLEN'(inhibit_q);
            default:       rdata = '0;
        endcase
        if (err) rdata = '0;
    end

    always_comb begin
        cnt_inc    = '0;
        cnt_inc[0] = !inhibit_q[0];
        cnt_inc[1] = i_retire && !inhibit_q[2];
        for (int k = 0; k < HPM_COUNTERS; k++)
            for (int j = 0; j < EVENT_WIDTH; j++)
                if (event_q[k] == EVT_W'(j + 1) && i_events[j] && !inhibit_q[3 + k])
                    cnt_inc[2 + k] = 1'b1;
    end

    // Slot 0 is mcycle, slot 1 minstret, slot 2+k mhpmcounter(3+k).
    for (genvar s = 0; s < NSLOT; s++) begin : g_cnt
        localparam int IDX = (s == 0) ? 0 : s + 1;
        assign cnt_wr_lo[s] = wr_ok && dec.sel == SEL_MCNT && !dec.high && int'(dec.index) == IDX;
        assign cnt_wr_hi[s] = wr_ok && dec.sel == SEL_MCNT &&  dec.high && int'(dec.index) == IDX;
        rice_csr_hpm_counter #(.XLEN(XLEN)) u_cnt (
            .clk_i   (i_clk),
            .rst_ni  (i_rst_n),
            .inc_i   (cnt_inc[s]),
            .wr_lo_i (cnt_wr_lo[s]),
            .wr_hi_i (cnt_wr_hi[s]),
            .wdata_i (req.data[XLEN-1:0]),
            .value_o (cnt_val[s]),
            .wrap_o  (cnt_wrap[s])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
            rdata_q     <= '0;
            counteren_q <= '0;
            inhibit_q   <= '0;
            for (int k = 0; k < OVF_W; k++) event_q[k] <= '0;
        end else begin
            ready_q <= req.valid;
            error_q <= req.valid && err;
            rdata_q <= req.valid ? rdata : '0;
            if (wr_ok && dec.sel == SEL_COUNTEREN) counteren_q <= req.data[31:0] & CNT_MASK;
            if (wr_ok && dec.sel == SEL_INHIBIT)   inhibit_q   <= req.data[31:0] & INH_MASK;
            for (int k = 0; k < HPM_COUNTERS; k++)
                if (wr_ok && dec.sel == SEL_EVENT && int'(dec.index) == 3 + k)
                    event_q[k] <= req.data[EVT_W-1:0];
        end
    end

    if (HPM_COUNTERS > 0) begin : g_ovf
        assign o_overflow = cnt_wrap[NSLOT-1:2];
    end else begin : g_no_ovf
        assign o_overflow = 1'b0;
    end

    // mcycle/minstret wrap silently; their wrap pulses are intentionally dropped.
    assign unused_sig      = ^{req.data, cnt_wrap[1:0]};
    assign o_csr_ready     = ready_q;
    assign o_csr_error     = error_q;
    assign o_csr_read_data = rdata_q;

endmodule

// File: tb/tb_rice_csr_hpm_counters.sv
// Directed bench for rice_csr_hpm_counters: one XLEN=32 and one XLEN=64 instance.
module tb_rice_csr_hpm_counters;

    localparam logic [1:0] PU = 2'd0;
    localparam logic [1:0] PM = 2'd3;

    logic        clk, rst_n;
    logic        v32, w32, rdy32, e32, ret32;
    logic [11:0] a32;
    logic [31:0] d32, r32;
    logic [1:0]  p32;
    logic [7:0]  ev32;
    logic [3:0]  ovf32;
    logic        v64, w64, rdy64, e64, ret64;
    logic [11:0] a64;
    logic [63:0] d64, r64;
    logic [1:0]  p64;
    logic [7:0]  ev64;
    logic [3:0]  ovf64;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] v1;

    rice_csr_hpm_counters #(.XLEN(32), .HPM_COUNTERS(4), .EVENT_WIDTH(8)) u_dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_csr_valid(v32), .i_csr_write(w32),
        .i_csr_address(a32), .i_csr_write_data(d32), .i_csr_privilege(p32),
        .o_csr_ready(rdy32), .o_csr_read_data(r32), .o_csr_error(e32),
        .i_retire(ret32), .i_events(ev32), .o_overflow(ovf32));

    rice_csr_hpm_counters #(.XLEN(64), .HPM_COUNTERS(4), .EVENT_WIDTH(8)) u_dut64 (
        .i_clk(clk), .i_rst_n(rst_n), .i_csr_valid(v64), .i_csr_write(w64),
        .i_csr_address(a64), .i_csr_write_data(d64), .i_csr_privilege(p64),
        .o_csr_ready(rdy64), .o_csr_read_data(r64), .o_csr_error(e64),
        .i_retire(ret64), .i_events(ev64), .o_overflow(ovf64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic req32(input logic wr, input logic [11:0] a, input logic [31:0] d, input logic [1:0] p);
        v32 = 1'b1; w32 = wr; a32 = a; d32 = d; p32 = p;
        @(posedge clk); #1;
        v32 = 1'b0; w32 = 1'b0;
        chk("ready32", 64'(rdy32), 64'd1);
    endtask

    task automatic req64(input logic wr, input logic [11:0] a, input logic [63:0] d, input logic [1:0] p);
        v64 = 1'b1; w64 = wr; a64 = a; d64 = d; p64 = p;
        @(posedge clk); #1;
        v64 = 1'b0; w64 = 1'b0;
        chk("ready64", 64'(rdy64), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        v32 = 0; w32 = 0; a32 = '0; d32 = '0; p32 = PM; ret32 = 0; ev32 = '0;
        v64 = 0; w64 = 0; a64 = '0; d64 = '0; p64 = PM; ret64 = 0; ev64 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(rdy32), 64'd0);
        chk("rst_rdata", 64'(r32),   64'd0);
        chk("rst_error", 64'(e32),   64'd0);
        chk("rst_ovf",   64'(ovf32), 64'd0);
        rst_n = 1'b1;

        // mcycle counts from the first clock after reset release
        repeat (10) @(posedge clk);
        #1;
        req32(1'b0, 12'hB00, 32'h0, PM);
        chk("mcycle10", 64'(r32), 64'd10);
        chk("mcycle10_err", 64'(e32), 64'd0);
        req32(1'b0, 12'hC00, 32'h0, PU);
        chk("u_cycle_noen_err", 64'(e32), 64'd1);
        chk("u_cycle_noen_data", 64'(r32), 64'd0);
        req32(1'b1, 12'h306, 32'h1, PM);
        chk("wr_mcounteren_err", 64'(e32), 64'd0);
        req32(1'b0, 12'hC00, 32'h0, PU);
        chk("u_cycle_en", 64'(r32), 64'd13);
        chk("u_cycle_en_err", 64'(e32), 64'd0);
        req32(1'b1, 12'hC00, 32'h55, PU);
        chk("u_write_err", 64'(e32), 64'd1);
        req32(1'b0, 12'hB00, 32'h0, PM);
        chk("mcycle_after_uwr", 64'(r32), 64'd15);
        @(posedge clk); #1;
        chk("ready_one_cycle", 64'(rdy32), 64'd0);

        // HPM3 wrap and overflow pulse
        req32(1'b1, 12'hB83, 32'hFFFF_FFFF, PM);
        req32(1'b1, 12'hB03, 32'hFFFF_FFFE, PM);
        req32(1'b1, 12'h323, 32'h2, PM);
        ev32 = 8'h02;
        @(posedge clk); #1;
        chk("ovf_before_wrap", 64'(ovf32), 64'd0);
        @(posedge clk); #1;
        chk("ovf_pulse", 64'(ovf32), 64'd1);
        ev32 = 8'h00;
        @(posedge clk); #1;
        chk("ovf_clear", 64'(ovf32), 64'd0);
        req32(1'b0, 12'hB03, 32'h0, PM);
        chk("hpm3_lo_wrapped", 64'(r32), 64'd0);
        req32(1'b0, 12'hB83, 32'h0, PM);
        chk("hpm3_hi_wrapped", 64'(r32), 64'd0);

        // hardwired bits and unimplemented indices
        req32(1'b1, 12'h306, 32'hFFFF_FFFF, PM);
        req32(1'b0, 12'h306, 32'h0, PM);
        chk("mcounteren_mask", 64'(r32), 64'h7F);
        req32(1'b0, 12'hC07, 32'h0, PU);
        chk("u_unimpl_err", 64'(e32), 64'd1);
        req32(1'b0, 12'hB07, 32'h0, PM);
        chk("unimpl_read", 64'(r32), 64'd0);
        chk("unimpl_err", 64'(e32), 64'd0);
        req32(1'b0, 12'h320, 32'h0, PU);
        chk("u_mrange_err", 64'(e32), 64'd1);
        req32(1'b1, 12'h320, 32'hFFFF_FFFF, PM);
        req32(1'b0, 12'h320, 32'h0, PM);
        chk("inhibit_mask", 64'(r32), 64'h7D);

        // inhibit freezes mcycle/minstret, clearing it resumes both
        req32(1'b1, 12'h320, 32'h5, PM);
        req32(1'b0, 12'hB00, 32'h0, PM);
        v1 = r32;
        ret32 = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        req32(1'b0, 12'hB00, 32'h0, PM);
        chk("mcycle_frozen", 64'(r32), 64'(v1));
        req32(1'b0, 12'hB02, 32'h0, PM);
        chk("minstret_frozen", 64'(r32), 64'd0);
        req32(1'b1, 12'h320, 32'h0, PM);
        req32(1'b0, 12'hB00, 32'h0, PM);
        chk("mcycle_resume0", 64'(r32), 64'(v1));
        req32(1'b0, 12'hB02, 32'h0, PM);
        chk("minstret_resume1", 64'(r32), 64'd1);
        req32(1'b0, 12'hB00, 32'h0, PM);
        chk("mcycle_resume2", 64'(r32), 64'(v1 + 32'd2));
        req32(1'b0, 12'hB02, 32'h0, PM);
        chk("minstret_resume3", 64'(r32), 64'd3);

        // write beats a same-cycle retire
        req32(1'b1, 12'hB02, 32'd100, PM);
        ret32 = 1'b0;
        req32(1'b0, 12'hB02, 32'h0, PM);
        chk("minstret_write_wins", 64'(r32), 64'd100);
        ret32 = 1'b1;
        @(posedge clk); #1;
        ret32 = 1'b0;
        req32(1'b0, 12'hB02, 32'h0, PM);
        chk("minstret_next_retire", 64'(r32), 64'd101);

        // XLEN=64 instance
        req64(1'b0, 12'hB07, 64'h0, PM);
        chk("x64_unimpl_read", r64, 64'd0);
        chk("x64_unimpl_err", 64'(e64), 64'd0);
        req64(1'b0, 12'hB80, 64'h0, PM);
        chk("x64_high_err", 64'(e64), 64'd1);
        chk("x64_high_data", r64, 64'd0);
        req64(1'b1, 12'h323, 64'd9, PM);
        req64(1'b0, 12'h323, 64'h0, PM);
        chk("x64_evt_readback", r64, 64'd9);
        ev64 = 8'hFF;
        repeat (5) @(posedge clk);
        #1;
        ev64 = 8'h00;
        req64(1'b0, 12'hB03, 64'h0, PM);
        chk("x64_evt_out_of_range", r64, 64'd0);
        req64(1'b1, 12'h323, 64'h12, PM);
        req64(1'b0, 12'h323, 64'h0, PM);
        chk("x64_evt_truncate", r64, 64'd2);
        ev64 = 8'hFF;
        @(posedge clk); #1;
        ev64 = 8'h00;
        req64(1'b0, 12'hB03, 64'h0, PM);
        chk("x64_evt_count", r64, 64'd1);
        req64(1'b1, 12'hB03, 64'h1_0000_0005, PM);
        req64(1'b0, 12'hB03, 64'h0, PM);
        chk("x64_full_write", r64, 64'h1_0000_0005);
        chk("x64_ovf_idle", 64'(ovf64), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rice_csr_hpm_counters.md
Name: rice_csr_hpm_counters

Overview:
- Parametrised machine/user performance-counter CSR block for the rice core.
- Successor to the fixed four-register read-only user counter block. Owns the counters instead of mirroring externally supplied values.
- Contents: 64-bit mcycle, minstret and HPM_COUNTERS programmable mhpmcounterN with event selectors, plus mcountinhibit and mcounteren.
- Sits beside the CSR file. Serves a simple CSR request port and returns a registered response.

Parameters:
- XLEN, 32: CSR data width, 32 or 64. Selects whether the high-half (…h) CSRs exist.
- HPM_COUNTERS, 4: implemented programmable counters, 0..29, mapped to indices 3..3+HPM_COUNTERS-1.
- EVENT_WIDTH, 8: number of event inputs, 1..255.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_csr_valid  input  1  CSR request strobe (single cycle)
- i_csr_write  input  1  1=write, 0=read
- i_csr_address  input  12  CSR number
- i_csr_write_data  input  XLEN  write data
- i_csr_privilege  input  2  requester privilege (0=U, 3=M)
- o_csr_ready  output  1  response strobe
- o_csr_read_data  output  XLEN  read data, valid with o_csr_ready
- o_csr_error  output  1  illegal access, valid with o_csr_ready
- i_retire  input  1  one instruction retired this cycle
- i_events  input  EVENT_WIDTH  event pulses for this cycle
- o_overflow  output  max(HPM_COUNTERS,1)  one-cycle pulse when mhpmcounter(3+k) wraps

Behaviour:
- Reset (async on i_rst_n low): all counters, mhpmevent, mcountinhibit, mcounteren cleared; all outputs 0.
  - A request in flight when reset asserts gets no response.
- Address map:
  - mcycle 0xB00, minstret 0xB02, mhpmcounterN 0xB00+N.
  - High halves at 0xB80+idx, only when XLEN=32.
  - User aliases at 0xC00+idx and 0xC80+idx.
  - mcounteren 0x306, mcountinhibit 0x320, mhpmeventN 0x320+N.
- Response timing:
  - o_csr_ready pulses exactly one cycle after i_csr_valid; one request per cycle sustained.
  - Read data is the CSR value at the request cycle, before that cycle's increment.
- Error conditions (ready=1, error=1, read data 0, no state change):
  - unmapped address;
  - 0xB80/0xC80 range when XLEN=64;
  - M-range access at U privilege;
  - any write to 0xCxx;
  - U read of 0xCxx whose mcounteren bit is 0.
- Unimplemented indices (3..31 beyond HPM_COUNTERS):
  - mhpmcounterN and mhpmeventN read 0; writes ignored; no error.
  - User aliases follow the same rule.
  - mcounteren/mcountinhibit bits for unimplemented indices and bit 1 of mcountinhibit are hardwired 0.
- Increment sources:
  - mcycle: +1 every cycle unless mcountinhibit[0].
  - minstret: +1 when i_retire and !mcountinhibit[2].
  - mhpmcounterN: +1 when e=mhpmevent N is in 1..EVENT_WIDTH, i_events[e-1]=1 and !mcountinhibit[N]. e=0 or e>EVENT_WIDTH never counts.
- mhpmevent storage: clog2(EVENT_WIDTH+1) bits; upper write bits discarded; reads zero-extended.
- Arithmetic: 64-bit unsigned, wraps from 2^64-1 to 0. On wrap of an HPM counter, o_overflow[k] pulses the cycle after the wrap (registered). mcycle/minstret wrap silently.
- Write vs increment: a write to either half of a counter wins. That counter does not increment in the write cycle and produces no carry.
  - XLEN=32 low write: low=wdata, high unchanged.
  - XLEN=32 high write: high=wdata, low unchanged.
  - XLEN=64: whole counter = wdata.
- Inhibit and event-select writes take effect from the next cycle's increment decision.

Decomposition:
- Package rice_csr_hpm_pkg:
  - CSR address constants;
  - privilege enum (U=0, M=3);
  - rice_csr_hpm_access_t struct (valid, write, address, data, privilege);
  - function decoding address to counter index and half.
- Sub-module rice_csr_hpm_counter: one 64-bit counter.
  - Inputs: increment, low/high write enables, write data, XLEN parameter.
  - Outputs: value and wrap pulse.
  - Instantiated 2+HPM_COUNTERS times in a generate loop.

Test Plan:
- Reset, idle 10 cycles, M read 0xB00 -> read data 10 (counted from the first clock after reset deassert), error=0; U read 0xC00 -> error=1, data 0.
- M write 0x306 = 0x1 then U read 0xC00 -> error=0, cycle value; U write 0xC00 -> error=1, counter unchanged.
- XLEN=32: write 0xB83=0xFFFFFFFF, 0xB03=0xFFFFFFFE, 0x323=2, pulse i_events[1] twice -> 0xB03 reads 0, 0xB83 reads 0, o_overflow[0] one-cycle pulse.
- mcountinhibit=0x5, 20 cycles with i_retire=1 -> mcycle and minstret frozen; clear inhibit -> both resume +1/cycle.
- Write 0xB02=100 in the same cycle i_retire=1 -> minstret reads 100 (not 101); next retire -> 101.
- HPM_COUNTERS=4, XLEN=64: read 0xB07 -> 0, error=0; read 0xB80 -> error=1; mhpmevent3=EVENT_WIDTH+1 with all events high -> no count.
